btn_event_arbiter: RTL and testbench
====================================

// Module: btn_event_arbiter
// PURPOSE
//  Front end for all user push-buttons. Each button gets a 2-FF synchroniser and a symmetric
//  debouncer. A debounced press becomes a pending event. A round-robin arbiter shares one
//  valid/ready event port between all buttons. Sits between board pins and the game/control FSM.
// PARAMETERS
//  N_BTN     4   number of buttons (2..16)
//  DB_BITS   16  debounce counter width; DB_MAX = 2^DB_BITS-1 (763 Hz equivalent at 50 MHz)
//  REP_BITS  24  auto-repeat interval counter width; REP_MAX = 2^REP_BITS-1 (used only with macro)
// PORTS
//  clk        in   1              system clock; all logic on posedge
//  rst_n      in   1              asynchronous, active-low reset
//  btn        in   N_BTN          raw asynchronous button pins, active high
//  btn_state  out  N_BTN          debounced button levels
//  evt_valid  out  1              event available
//  evt_ready  in   1              consumer accepts event when evt_valid & evt_ready
//  evt_id     out  clog2(N_BTN)   index of button that produced event
//  evt_rep    out  1              1 = auto-repeat event, 0 = initial press
//  evt_ovr    out  1              1-cycle pulse: press lost because button already pending
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - sync FFs, btn_state, counters, pend/rep flags, evt_valid, evt_id, evt_rep and evt_ovr all 0.
//   - RR pointer = N_BTN-1, so button 0 has highest priority first.
//   - Reset is allowed mid-debounce or mid-handshake; the in-flight event is discarded.
//  Sync: s[i] = btn[i] after 2 clk stages.
//  Debounce, per button, cnt[i] is DB_BITS wide:
//   - s!=state & cnt<DB_MAX: cnt++.
//   - s!=state & cnt==DB_MAX: state<=s, cnt<=0.
//   - s==state: cnt<=0. Any bounce restarts the count.
//   - Both edges are debounced. btn_state flips DB_MAX+3 clks after the last btn edge.
//  Pending, per button:
//   - Set on the btn_state 0->1 edge.
//   - Cleared in the cycle the arbiter grants the button.
//   - Set and grant of the same button in the same cycle: set wins, so the button stays pending.
//   - Rising edge while already pending and not granted that cycle: the event coalesces and
//     evt_ovr=1 for 1 clk.
//  Arbiter/output FSM:
//   - EMPTY (evt_valid=0) / FULL (evt_valid=1).
//   - Load condition: !evt_valid | evt_ready.
//   - On load, the first pending button searching ptr+1, ptr+2, ... (mod N_BTN) is granted.
//     evt_id, evt_rep and evt_valid<=1 are registered, and ptr<=granted index.
//   - If load and nothing is pending: evt_valid<=0.
//   - While evt_valid & !evt_ready: evt_id and evt_rep hold stable.
//   - Latency: evt_valid rises 1 clk after pend sets. Throughput is 1 event/clk with ready held high.
// CONFIGURATION
//  AUTOREPEAT_EN defined:
//   - Per-button rcnt[i] (REP_BITS) clears when btn_state[i]=0 and counts while it is 1.
//   - At REP_MAX: rcnt wraps to 0, pend[i]<=1 and rep[i]<=1. Same coalesce/ovr rule applies.
//   - An initial-press set clears rep[i].
//   - evt_rep reports rep of the granted button.
//  AUTOREPEAT_EN undefined: no rcnt logic; evt_rep tied 0; REP_BITS ignored.
// TESTING (N_BTN=4, DB_BITS=4 -> DB_MAX=15, REP_BITS=5 -> REP_MAX=31)
//  1 rst_n=0 with btn=4'hF -> all outputs 0. Release reset, btn held -> btn_state=F 18 clks after
//    release; events in order id 0,1,2,3 with ready=1.
//  2 btn[1] toggles every 5 clks for 60 clks, then stays 1 -> btn_state[1] stays 0 during bounce
//    and rises 18 clks after the final edge; exactly one event, id=1, rep=0.
//  3 btn[0] and btn[2] rise in the same clk, ready=1 -> id=0 then id=2 on consecutive clks;
//    evt_valid then drops.
//  4 ready=0, btn[3] press/release/press (each phase 40 clks) -> single event id=3 held stable;
//    evt_ovr pulses once at the second press.
//  5 rst_n pulsed low for 1 clk while evt_valid=1, ready=0 -> evt_valid=0 immediately (async);
//    no stale event after reset.
//  6 AUTOREPEAT_EN, btn[2] held 120 clks, ready=1 -> one rep=0 event, then rep=1 events every
//    32 clks; none after release.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: per-button synchroniser + debouncer feeding a round-robin
// arbiter that shares one valid/ready event port between all buttons.
// Optional auto-repeat events are enabled by defining AUTOREPEAT_EN.

// One button lane: 2-FF synchroniser and symmetric debouncer.
module btn_lane #(
    parameter int DB_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic state,
    output logic rise
);
    localparam logic [DB_BITS-1:0] DB_MAX = '1;

    logic               s1, s2;
    logic [DB_BITS-1:0] cnt;

    // two-stage synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // state follows s2 only after DB_MAX+1 consecutive mismatching samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (s2 != state) begin
            if (cnt == DB_MAX) begin
                state <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // high in the cycle whose clock edge flips state 0->1
    assign rise = s2 & ~state & (cnt == DB_MAX);
endmodule

module btn_event_arbiter #(
    parameter int N_BTN    = 4,
    parameter int DB_BITS  = 16,
    parameter int REP_BITS = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn,
    output logic [N_BTN-1:0]         btn_state,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_rep,
    output logic                     evt_ovr
);
    localparam int IDW = $clog2(N_BTN);

    typedef enum logic {EMPTY, FULL} st_t;

    st_t              st, st_nxt;
    logic [IDW-1:0]   ptr, gnt_id;
    logic             found, load;
    logic [N_BTN-1:0] state, rise, rtick, set, held, pend, gnt;

    if (N_BTN < 2 || N_BTN > 16 || DB_BITS < 1 || REP_BITS < 1) begin : g_param_err
        $error("btn_event_arbiter: parameter out of range");
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_lane
        btn_lane #(.DB_BITS(DB_BITS)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn[gi]),
            .state (state[gi]),
            .rise  (rise[gi])
        );
`ifdef AUTOREPEAT_EN
        logic [REP_BITS-1:0] rcnt;
        // repeat interval counter: runs while the button is held, wraps at REP_MAX
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)          rcnt <= '0;
            else if (!state[gi]) rcnt <= '0;
            else                 rcnt <= rcnt + 1'b1;
        end
        assign rtick[gi] = state[gi] & (rcnt == '1);
`else
        assign rtick[gi] = 1'b0;
`endif
        // this button's event sits unaccepted in the output register; a new
        // set coalesces into it rather than producing a second event
        assign held[gi] = evt_valid & ~evt_ready & (evt_id == IDW'(gi));
    end

    assign btn_state = state;
    assign set       = rise | rtick;
    assign evt_valid = (st == FULL);
    assign load      = (st == EMPTY) | evt_ready;

    // round-robin search from ptr+1 and next-state decode
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        gnt    = '0;
        st_nxt = st;
        for (int k = 1; k <= N_BTN; k++) begin
            int c;
            c = (int'(ptr) + k) % N_BTN;
            if (!found && pend[c]) begin
                found  = 1'b1;
                gnt_id = IDW'(c);
            end
        end
        if (load) begin
            gnt[gnt_id] = found;
            st_nxt      = found ? FULL : EMPTY;
        end
    end

    // FSM state, output register, pending flags and overrun pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= EMPTY;
            ptr     <= IDW'(N_BTN - 1);
            evt_id  <= '0;
            pend    <= '0;
            evt_ovr <= 1'b0;
        end else begin
            st <= st_nxt;
            if (load && found) begin
                ptr    <= gnt_id;
                evt_id <= gnt_id;
            end
            // set beats a same-cycle grant, so the button stays pending
            pend    <= (pend & ~gnt) | (set & ~held);
            evt_ovr <= |(set & ((pend & ~gnt) | held));
        end
    end

`ifdef AUTOREPEAT_EN
    logic [N_BTN-1:0] rep;
    // rep flag per button: cleared by a fresh press, set by a repeat tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep     <= '0;
            evt_rep <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (rise[i])                  rep[i] <= 1'b0;
                else if (rtick[i] && !held[i]) rep[i] <= 1'b1;
            end
            if (load && found) evt_rep <= rep[gnt_id];
        end
    end
`else
    assign evt_rep = 1'b0;
`endif
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter (N_BTN=4, DB_MAX=15, REP_MAX=31).
module tb_btn_event_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] btn_state;
    logic       evt_valid, evt_ready, evt_rep, evt_ovr;
    logic [1:0] evt_id;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int mptr = 3;
    int bad;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;

    btn_event_arbiter #(.N_BTN(4), .DB_BITS(4), .REP_BITS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .btn_state (btn_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_rep   (evt_rep),
        .evt_ovr   (evt_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // push expected events for buttons that become pending together, in RR order
    task automatic push_rr(input logic [3:0] mask, input logic rep);
        int base;
        base = mptr;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (base + k) % 4;
            if (mask[c]) begin
                sb.push_back({3'b000, rep, 4'(c)});
                mptr = c;
            end
        end
    endtask

    // consume handshakes and compare against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (evt_ovr) ovr_cnt++;
            if (evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    chk("evt_unexpected", {27'd0, evt_rep, 2'b00, evt_id}, 32'hFF);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("evt", {27'd0, evt_rep, 2'b00, evt_id}, {24'd0, mon_exp});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        btn = 4'hF;
        evt_ready = 1'b1;

        // 1: reset with all buttons held, then four events in index order
        repeat (3) step();
        chk("rst_state", btn_state, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_rep", evt_rep, 0);
        chk("rst_ovr", evt_ovr, 0);
        mptr = 3;
        push_rr(4'hF, 1'b0);
        rst_n = 1'b1;
        repeat (17) step();
        chk("t1_state_pre", btn_state, 4'h0);
        step();
        chk("t1_state", btn_state, 4'hF);
        repeat (10) step();
        chk("t1_drain", sb.size(), 0);
        btn = 4'h0;
        repeat (25) step();
        chk("t1_release", btn_state, 4'h0);

        // 2: bouncing btn[1] -> one clean event
        push_rr(4'b0010, 1'b0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            btn[1] = ~btn[1];
            repeat (5) begin
                step();
                if (btn_state[1]) bad++;
            end
        end
        chk("t2_bounce", bad, 0);
        btn[1] = 1'b1;
        repeat (17) step();
        chk("t2_pre", btn_state[1], 0);
        step();
        chk("t2_rise", btn_state[1], 1);
        repeat (10) step();
        chk("t2_drain", sb.size(), 0);
        btn[1] = 1'b0;
        repeat (25) step();

        // 4: ready low, press/release/press -> one held event and one overrun
        evt_ready = 1'b0;
        push_rr(4'b1000, 1'b0);
        ovr_cnt = 0;
        bad = 0;
        btn[3] = 1'b1;
        repeat (40) step();
        btn[3] = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (i == 40) btn[3] = 1'b1;
            step();
            if (!(evt_valid === 1'b1 && evt_id === 2'd3)) bad++;
        end
        chk("t4_hold", bad, 0);
        chk("t4_ovr", ovr_cnt, 1);
        evt_ready = 1'b1;
        repeat (5) step();
        chk("t4_single", evt_valid, 0);
        chk("t4_drain", sb.size(), 0);
        btn[3] = 1'b0;
        repeat (25) step();

        // 5: reset mid-handshake discards the in-flight event
        evt_ready = 1'b0;
        btn[0] = 1'b1;
        for (int i = 0; i < 40 && !evt_valid; i++) step();
        chk("t5_valid", evt_valid, 1);
        btn[0] = 1'b0;
        repeat (25) step();
        rst_n = 1'b0;
        #1;
        chk("t5_async", evt_valid, 0);
        mptr = 3;
        step();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        bad = 0;
        repeat (40) begin
            step();
            if (evt_valid) bad++;
        end
        chk("t5_stale", bad, 0);

        // 3: simultaneous presses -> id 0 then id 2 on consecutive cycles
        push_rr(4'b0101, 1'b0);
        btn = 4'b0101;
        repeat (18) step();
        chk("t3_state", btn_state, 4'b0101);
        chk("t3_lat", evt_valid, 0);
        step();
        chk("t3_v1", evt_valid, 1);
        chk("t3_id0", evt_id, 0);
        step();
        chk("t3_v2", evt_valid, 1);
        chk("t3_id2", evt_id, 2);
        step();
        chk("t3_drop", evt_valid, 0);
        btn = 4'h0;
        repeat (25) step();

`ifdef AUTOREPEAT_EN
        // 6: held button -> initial press then repeats every 32 clks
        push_rr(4'b0100, 1'b0);
        repeat (3) push_rr(4'b0100, 1'b1);
        btn[2] = 1'b1;
        repeat (120) step();
        btn[2] = 1'b0;
        repeat (60) step();
        chk("t6_state", btn_state, 4'h0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
